// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-port AXI request arbiter.
// Requester 0 is the I-cache refill, requester 1 the D-cache refill/write-back.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int unsigned N_REQ      = 2;
    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_DCACHE = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. The last-grant register moves only when update
// is asserted together with a valid pick.
module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             update,
    output logic             gnt_id,
    output logic             gnt_valid
);

    logic last_q, last_d;

    always_comb begin
        gnt_valid = |req;
        // On contention the requester not granted last wins; otherwise the lone requester.
        if (req[REQ_ICACHE] && req[REQ_DCACHE]) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = req[REQ_DCACHE];
        end
        last_d = last_q;
        if (update && gnt_valid) begin
            last_d = gnt_id;
        end
    end

    // Reset to "last granted = 1" so requester 0 holds priority out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one AXI controller between the I-cache and D-cache requesters, one
// transaction at a time, with registered request, ack and read-data outputs.
module axi_req_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ack,
    output logic [DATA_W-1:0]       req_rdata,
    output logic                    w_req,
    output logic                    r_req,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    ack,
    output logic                    busy,
    output logic                    grant_id
);

    arb_state_e        state_q, state_d;
    logic              dir_q, dir_d;
    logic              w_req_q, w_req_d;
    logic              r_req_q, r_req_d;
    logic              busy_q, busy_d;
    logic              grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              gnt_id, gnt_valid, arb_update;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .update    (arb_update),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        sel_addr  = gnt_id ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
        sel_wdata = gnt_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        sel_we    = req_we[gnt_id];
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ack_d      = '0;
        arb_update = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    arb_update = 1'b1;
                    state_d    = BUSY;
                    dir_d      = sel_we;
                    grant_d    = gnt_id;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                end
            end
            BUSY: begin
                if (ack) begin
                    state_d         = RESP;
                    rdata_d         = mem_rdata;
                    ack_d[grant_q]  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Request lines are a pure function of the next state so they can never overlap.
        w_req_d = (state_d == BUSY) &&  dir_d;
        r_req_d = (state_d == BUSY) && !dir_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            w_req_q <= 1'b0;
            r_req_q <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
            ack_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            w_req_q <= w_req_d;
            r_req_q <= r_req_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ack   = ack_q;
    assign req_rdata = rdata_q;
    assign w_req     = w_req_q;
    assign r_req     = r_req_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: the main process plays requesters and the
// AXI controller, a monitor pops expected completions whenever req_ack pulses.
module tb_axi_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_ack;
    logic [31:0] req_rdata;
    logic        w_req, r_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        ack = 1'b0;
    logic        busy;
    logic        grant_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    axi_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .req_rdata (req_rdata),
        .w_req     (w_req),
        .r_req     (r_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ack       (ack),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int port, input bit we, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.we   = we;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Acts as the AXI controller for one granted transaction; ack comes in BUSY cycle lat.
    task automatic serve(input int lat, input logic [31:0] rd, input int port, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] drop);
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            check("grant_timeout", {63'd0, busy}, 64'd1);
            return;
        end
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            check("busy", {63'd0, busy}, 64'd1);
            check("grant_id", {63'd0, grant_id}, port);
            check("w_req", {63'd0, w_req}, {63'd0, we});
            check("r_req", {63'd0, r_req}, {63'd0, !we});
            check("mem_addr", {32'd0, mem_addr}, {32'd0, addr});
            if (we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
            if (k == lat) begin
                ack       = 1'b1;
                mem_rdata = rd;
            end
        end
        @(negedge clk);
        ack       = 1'b0;
        mem_rdata = '0;
        check("resp_busy", {63'd0, busy}, 64'd1);
        check("resp_reqs_low", {62'd0, w_req, r_req}, 64'd0);
        req_valid = req_valid & ~drop;
        @(negedge clk);
        check("idle_after_ack", {63'd0, busy}, 64'd0);
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (w_req && r_req) check("req_overlap", {62'd0, w_req, r_req}, 64'd2);
            if (req_ack != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {62'd0, req_ack}, 64'd0);
                end else begin
                    exp_t e;
                    logic [1:0] m;
                    e = exp_q.pop_front();
                    m = 2'b01 << e.port;
                    check("ack_port", {62'd0, req_ack}, {62'd0, m});
                    if (!e.we) check("req_rdata", {32'd0, req_rdata}, {32'd0, e.data});
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {req_ack, w_req, r_req, busy, grant_id}, 64'd0);
        check("reset_data", {mem_addr, req_rdata}, 64'd0);
        check("reset_wdata", {32'd0, mem_wdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single read on port 0
        req_we          = 2'b00;
        req_addr[31:0]  = 32'h0000_1000;
        req_valid       = 2'b01;
        push_exp(0, 1'b0, 32'hDEAD_BEEF);
        serve(3, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_1000, 32'h0, 2'b01);

        // Spurious ack in IDLE
        ack       = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        ack       = 1'b0;
        mem_rdata = '0;
        check("spur_busy", {63'd0, busy}, 64'd0);
        check("spur_rdata", {32'd0, req_rdata}, 64'hDEAD_BEEF);
        check("spur_outputs", {req_ack, w_req, r_req}, 64'd0);
        @(negedge clk);
        check("spur_still_idle", {63'd0, busy}, 64'd0);

        // Single write on port 1
        req_we              = 2'b10;
        req_addr[63:32]     = 32'h0000_2004;
        req_wdata[63:32]    = 32'hA5A5_A5A5;
        req_valid           = 2'b10;
        push_exp(1, 1'b1, 32'h0);
        serve(2, 32'h0, 1, 1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 2'b10);

        // Contention right after reset: grants must alternate 0,1,0,1
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_we          = 2'b00;
        req_addr[31:0]  = 32'h0000_0100;
        req_addr[63:32] = 32'h0000_0200;
        for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, 32'h1111_0000 + i);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            serve(2, 32'h1111_0000 + i, i % 2, 1'b0, (i % 2) ? 32'h200 : 32'h100, 32'h0,
                  (i == 3) ? 2'b11 : 2'b00);
        end

        // Payload change and valid drop while BUSY are ignored
        req_addr[31:0] = 32'h0000_1000;
        req_valid      = 2'b01;
        push_exp(0, 1'b0, 32'hCAFE_F00D);
        @(negedge clk);
        req_addr[31:0] = 32'h0000_3000;
        req_valid      = 2'b00;
        serve(3, 32'hCAFE_F00D, 0, 1'b0, 32'h0000_1000, 32'h0, 2'b01);

        // Reset two cycles after a port-0 grant, then port 0 must win contention
        req_addr[31:0] = 32'h0000_1000;
        req_valid      = 2'b01;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_outputs", {req_ack, w_req, r_req, busy, grant_id}, 64'd0);
        check("midrst_data", {mem_addr, req_rdata}, 64'd0);
        check("midrst_wdata", {32'd0, mem_wdata}, 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        req_addr[31:0]  = 32'h0000_4000;
        req_addr[63:32] = 32'h0000_5000;
        push_exp(0, 1'b0, 32'h4444_4444);
        push_exp(1, 1'b0, 32'h5555_5555);
        req_valid = 2'b11;
        serve(2, 32'h4444_4444, 0, 1'b0, 32'h0000_4000, 32'h0, 2'b01);
        serve(2, 32'h5555_5555, 1, 1'b0, 32'h0000_5000, 32'h0, 2'b10);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
